// File: rtl/fir_mac_sched.sv
// Control scheduler for a folded symmetric FIR with one shared MAC: per sample it sequences the delay-line write, NPAIR+1 folded-tap MAC steps and the output load.
// Optional sticky dropped-sample flag enabled by defining FIR_MAC_SCHED_OVERRUN_EN.
`timescale 1ns/1ps
module fir_mac_sched #(
    parameter int NUM_TAPS = 101,
    parameter int AW       = 7,
    parameter int CW       = 6
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          sam_clk_en,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [CW-1:0] coef_addr,
    output logic          pair_sel,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          y_load,
    output logic          busy,
    output logic          overrun
);

    localparam int            NPAIR     = (NUM_TAPS - 1) / 2;
    localparam logic [CW-1:0] K_LAST    = CW'(NPAIR);
    localparam logic [AW:0]   TAPS_W    = (AW+1)'(NUM_TAPS);
    localparam logic [AW-1:0] WPTR_LAST = AW'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic [AW-1:0] wptr_q, wptr_d;

    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [AW-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [CW-1:0] coef_addr_q, coef_addr_d;
    logic          pair_sel_q, pair_sel_d;
    logic          acc_clr_q, acc_clr_d;
    logic          acc_en_q, acc_en_d;
    logic          y_load_q, y_load_d;
    logic          busy_q, busy_d;

    // Both operands are below NUM_TAPS, so one conditional correction keeps the result in range.
    function automatic logic [AW-1:0] addr_sub(input logic [AW-1:0] wp, input logic [CW-1:0] k);
        logic [AW:0] w;
        logic [AW:0] kk;
        w  = {1'b0, wp};
        kk = (AW+1)'(k);
        if (w >= kk) begin
            return AW'(w - kk);
        end else begin
            return AW'(w + TAPS_W - kk);
        end
    endfunction

    function automatic logic [AW-1:0] addr_add1(input logic [AW-1:0] wp, input logic [CW-1:0] k);
        logic [AW:0] s;
        s = {1'b0, wp} + (AW+1)'(k) + (AW+1)'(1'b1);
        if (s >= TAPS_W) begin
            return AW'(s - TAPS_W);
        end else begin
            return AW'(s);
        end
    endfunction

    // Next-state logic: tap-pair counter and write pointer advance.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wptr_d  = wptr_q;
        case (state_q)
            ST_IDLE: begin
                if (sam_clk_en) begin
                    state_d = ST_CLR;
                end else begin
                    state_d = ST_IDLE;
                end
                k_d = '0;
            end
            ST_CLR: begin
                state_d = ST_RUN;
                k_d     = '0;
            end
            ST_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DUMP;
                end else begin
                    k_d = k_q + CW'(1'b1);
                end
            end
            ST_DUMP: begin
                state_d = ST_IDLE;
                k_d     = '0;
                if (wptr_q == WPTR_LAST) begin
                    wptr_d = '0;
                end else begin
                    wptr_d = wptr_q + AW'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop aligned with its state.
    always_comb begin
        wr_en_d     = 1'b0;
        acc_clr_d   = 1'b0;
        acc_en_d    = 1'b0;
        pair_sel_d  = 1'b0;
        y_load_d    = 1'b0;
        busy_d      = 1'b0;
        wr_addr_d   = wr_addr_q;
        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        coef_addr_d = coef_addr_q;
        case (state_d)
            ST_CLR: begin
                wr_en_d   = 1'b1;
                acc_clr_d = 1'b1;
                busy_d    = 1'b1;
                wr_addr_d = wptr_q;
            end
            ST_RUN: begin
                acc_en_d    = 1'b1;
                busy_d      = 1'b1;
                coef_addr_d = k_d;
                rd_addr_a_d = addr_sub(wptr_q, k_d);
                if (k_d == K_LAST) begin
                    rd_addr_b_d = addr_sub(wptr_q, k_d);
                    pair_sel_d  = 1'b0;
                end else begin
                    rd_addr_b_d = addr_add1(wptr_q, k_d);
                    pair_sel_d  = 1'b1;
                end
            end
            ST_DUMP: begin
                y_load_d = 1'b1;
                busy_d   = 1'b1;
            end
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            wptr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            coef_addr_q <= '0;
            pair_sel_q  <= 1'b0;
            acc_clr_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            y_load_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wptr_q      <= wptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            coef_addr_q <= coef_addr_d;
            pair_sel_q  <= pair_sel_d;
            acc_clr_q   <= acc_clr_d;
            acc_en_q    <= acc_en_d;
            y_load_q    <= y_load_d;
            busy_q      <= busy_d;
        end
    end

`ifdef FIR_MAC_SCHED_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Any strobe arriving while a sample is in flight is lost; remember it until reset.
    always_comb begin
        overrun_d = overrun_q | (sam_clk_en & busy_q);
    end

    // Sticky overrun flag register.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign coef_addr = coef_addr_q;
    assign pair_sel  = pair_sel_q;
    assign acc_clr   = acc_clr_q;
    assign acc_en    = acc_en_q;
    assign y_load    = y_load_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Bench for fir_mac_sched: per-cycle schedule checks against a cycle-offset model, plus a
// behavioural delay-line/MAC datapath whose outputs are compared with a direct convolution.
`timescale 1ns/1ps
module tb_fir_mac_sched;
    localparam int N     = 101;
    localparam int NP    = 50;
    localparam int AW    = 7;
    localparam int CW    = 6;
    localparam int TLAST = NP + 3;
`ifdef FIR_MAC_SCHED_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          reset = 1'b0;
    logic          sam_clk_en = 1'b0;
    logic          wr_en, pair_sel, acc_clr, acc_en, y_load, busy, overrun;
    logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [CW-1:0] coef_addr;

    fir_mac_sched #(.NUM_TAPS(N), .AW(AW), .CW(CW)) dut (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .coef_addr(coef_addr), .pair_sel(pair_sel), .acc_clr(acc_clr), .acc_en(acc_en),
        .y_load(y_load), .busy(busy), .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;

    int     h [N];
    int     mem [2**AW];
    longint acc_q, y_q;
    int     y_cnt = 0;
    int     sample_x = 0;

    // Attached datapath: delay-line RAM, folded pre-add, shared accumulator, output register.
    always @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= 0;
            acc_q <= 0;
            y_q   <= 0;
        end else begin
            if (wr_en) mem[wr_addr] <= sample_x;
            if (acc_clr) acc_q <= 0;
            else if (acc_en)
                acc_q <= acc_q + longint'(h[coef_addr]) *
                         (pair_sel ? longint'(mem[rd_addr_a]) + longint'(mem[rd_addr_b])
                                   : longint'(mem[rd_addr_a]));
            if (y_load) y_q <= acc_q;
        end
    end

    always @(posedge sys_clk) if (y_load) y_cnt <= y_cnt + 1;

    int     n_checks = 0, n_pass = 0;
    int     wp_m = 0, last_wr = 0, last_a = 0, last_b = 0, last_coef = 0, exp_y = 0;
    bit     ovr_m = 1'b0;
    longint last_ref = 0;
    int     hist[$];

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int mod_n(input int v);
        return ((v % N) + N) % N;
    endfunction

    // Direct-form convolution over the accepted-sample history (newest first).
    function automatic longint ref_y();
        longint s = 0;
        for (int i = 0; i < N && i < hist.size(); i++) s += longint'(h[i]) * longint'(hist[i]);
        return s;
    endfunction

    // t = 0 is an idle cycle; t = 1..TLAST is the cycle offset after the accepted strobe.
    task automatic check_cycle(input int t);
        int k;
        bit run;
        k   = t - 2;
        run = (t >= 2) && (t <= TLAST - 1);
        if (t == 1) last_wr = wp_m;
        if (run) begin
            last_coef = k;
            if (k < NP) begin
                last_a = mod_n(wp_m - k);
                last_b = mod_n(wp_m + 1 + k);
            end else begin
                last_a = mod_n(wp_m - NP);
                last_b = last_a;
            end
        end
        check_eq("busy", busy, t >= 1);
        check_eq("wr_en", wr_en, t == 1);
        check_eq("acc_clr", acc_clr, t == 1);
        check_eq("acc_en", acc_en, run);
        check_eq("pair_sel", pair_sel, run && (k < NP));
        check_eq("y_load", y_load, t == TLAST);
        check_eq("wr_addr", wr_addr, last_wr);
        check_eq("rd_addr_a", rd_addr_a, last_a);
        check_eq("rd_addr_b", rd_addr_b, last_b);
        check_eq("coef_addr", coef_addr, last_coef);
        check_eq("overrun", overrun, ovr_m);
        if (t == 0) begin
            check_eq("y_count", y_cnt, exp_y);
            check_eq("y_value", y_q, last_ref);
        end
    endtask

    // One sample: optional idle gap, strobe, full schedule check; optional extra strobe or reset.
    task automatic run_sample(input int x, input int gap, input int inj_t, input int rst_t);
        longint r;
        for (int g = 0; g < gap; g++) begin
            @(negedge sys_clk);
            check_cycle(0);
            sam_clk_en = 1'b0;
        end
        @(negedge sys_clk);
        check_cycle(0);
        sam_clk_en = 1'b1;
        sample_x   = x;
        hist.push_front(x);
        for (int t = 1; t <= TLAST; t++) begin
            @(negedge sys_clk);
            check_cycle(t);
            if (t == TLAST) begin
                r = ref_y();
                check_eq("acc_result", acc_q, r);
            end
            sam_clk_en = (t == inj_t);
            if (t == inj_t && OVR_EN) ovr_m = 1'b1;
            if (t == rst_t) begin
                sam_clk_en = 1'b0;
                reset = 1'b0;
                #1;
                wp_m = 0; last_wr = 0; last_a = 0; last_b = 0; last_coef = 0;
                ovr_m = 1'b0; last_ref = 0;
                hist.delete();
                check_cycle(0);
                @(negedge sys_clk);
                reset = 1'b1;
                return;
            end
        end
        wp_m     = (wp_m + 1) % N;
        exp_y    = exp_y + 1;
        last_ref = r;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i <= NP; i++) begin
            h[i]         = int'($urandom_range(0, 200)) - 100;
            h[N - 1 - i] = h[i];
        end
        reset = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_cycle(0);
        reset = 1'b1;

        // Impulse: 101 outputs equal to the coefficient list, write pointer sweeps 0..100.
        run_sample(1, 0, 0, 0);
        for (int i = 0; i < N - 1; i++) run_sample(0, 0, 0, 0);
        run_sample(int'($urandom_range(0, 255)) - 128, 0, 0, 0);

        // Mid-sample strobe is dropped.
        run_sample(int'($urandom_range(0, 255)) - 128, 2, 20, 0);
        // Reset mid-RUN aborts the sample.
        run_sample(int'($urandom_range(0, 255)) - 128, 1, 0, 30);
        // Strobe in DUMP is dropped; the next one back-to-back is accepted.
        run_sample(int'($urandom_range(0, 255)) - 128, 1, TLAST, 0);
        run_sample(int'($urandom_range(0, 255)) - 128, 0, 0, 0);

        for (int i = 0; i < 15; i++)
            run_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TLAST)) : 0, 0);

        @(negedge sys_clk);
        check_cycle(0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fir_mac_sched.md
FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

Interface
REQ-001 Parameter NUM_TAPS, default 101, SHALL set the odd symmetric FIR length; NPAIR = (NUM_TAPS-1)/2 (50 by default).
REQ-002 Parameter AW, default 7, SHALL set the delay-line address width, with 2^AW >= NUM_TAPS.
REQ-003 Parameter CW, default 6, SHALL set the coefficient address width, with 2^CW > NPAIR.
REQ-004 sys_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 sam_clk_en  in  1  SHALL be the one-cycle sample strobe: new input sample available.
REQ-007 wr_en  out  1  SHALL strobe a write of the current sample into the delay-line RAM.
REQ-008 wr_addr  out  AW  SHALL give the delay-line write address.
REQ-009 rd_addr_a, rd_addr_b  out  AW each  SHALL give the two folded-tap read addresses.
REQ-010 coef_addr  out  CW  SHALL give the coefficient ROM address (tap-pair index k).
REQ-011 pair_sel  out  1  SHALL be 1 = pre-add both taps, 0 = center tap only (b ignored).
REQ-012 acc_clr, acc_en  out  1 each  SHALL clear and enable the shared MAC accumulator.
REQ-013 y_load  out  1  SHALL strobe the output register to capture the finished accumulator.
REQ-014 busy  out  1  SHALL be high while a sample is being processed.
REQ-015 overrun  out  1  SHALL be a sticky flag for a dropped sample (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, CLR, RUN and DUMP; all outputs SHALL be registered.
REQ-017 IDLE->CLR SHALL occur on sam_clk_en=1 (cycle T0); a strobe in any other state SHALL be ignored.
REQ-018 In CLR (T1), the block SHALL drive wr_en=1, wr_addr=wptr and acc_clr=1 for exactly one cycle.
REQ-019 In RUN (T2..T2+NPAIR), k SHALL count 0..NPAIR, one per cycle, with acc_en=1 and coef_addr=k.
REQ-020 For k<NPAIR, the block SHALL drive rd_addr_a=(wptr-k) mod NUM_TAPS, rd_addr_b=(wptr+1+k) mod NUM_TAPS and pair_sel=1.
REQ-021 For k=NPAIR, the block SHALL drive rd_addr_a=rd_addr_b=(wptr-NPAIR) mod NUM_TAPS and pair_sel=0.
REQ-022 Modulo arithmetic SHALL wrap within 0..NUM_TAPS-1 only and never emit an address >= NUM_TAPS.
REQ-023 After k=NPAIR, the FSM SHALL enter DUMP for one cycle with y_load=1, set wptr=(wptr+1) mod NUM_TAPS, then return to IDLE.
REQ-024 busy SHALL be 1 from T1 through the DUMP cycle inclusive (NPAIR+3 cycles, 53 by default).
REQ-025 The minimum accepted sample spacing SHALL be NPAIR+4 cycles (54 by default); sam_clk_en in the DUMP cycle SHALL be dropped.
REQ-026 acc_en, acc_clr, wr_en, y_load and pair_sel SHALL be 0 in every cycle outside their stated windows; address outputs SHALL hold their last values.

Reset
REQ-027 On reset=0, the block SHALL asynchronously enter IDLE with k=0, wptr=0 and all outputs 0.
REQ-028 Reset asserted mid-CLR/RUN/DUMP SHALL abort the sample with no y_load; after release the block SHALL wait in IDLE for a fresh strobe.

Configuration
REQ-029 With macro FIR_MAC_SCHED_OVERRUN_EN defined, overrun SHALL set one cycle after any sam_clk_en seen while busy=1 and hold until reset.
REQ-030 Without FIR_MAC_SCHED_OVERRUN_EN, overrun SHALL be constant 0 with no detection logic; dropping behaviour SHALL be unchanged.

Verification
REQ-031 Reset, then one strobe -> wr_en at T1 with wr_addr=0; RUN k=0 gives a=0, b=1; k=49 gives a=52, b=50; k=50 gives a=b=51, pair_sel=0; y_load at T53.
REQ-032 101 strobes spaced 54 cycles -> wr_addr steps 0..100 then wraps to 0; exactly 101 y_load pulses.
REQ-033 Impulse sample 1 followed by zeros, with the datapath attached -> y sequence equals the coefficient list, symmetric, 101 outputs.
REQ-034 Strobe at T0, second strobe at T20 -> second strobe dropped; overrun=1 from T21 when FIR_MAC_SCHED_OVERRUN_EN is defined, 0 otherwise.
REQ-035 Reset pulsed at T30 mid-RUN -> outputs 0 immediately, no y_load, wptr=0; next strobe processes normally from wr_addr=0.
REQ-036 Strobe exactly at the DUMP cycle (T53) -> ignored; strobe at T54 -> accepted with wr_addr=1.
